// File: rtl/cbd_byte_loader_if.sv
// Handshake and data bus between the SHAKE256 squeeze port, the byte loader and the cbd sampler.
// "master" is the producer/consumer side; "slave" is the loader.
interface cbd_byte_loader_if #(
  parameter int BEAT_BYTES = 8
);
  logic                    i_start;
  logic [1:0]              i_eta;
  logic                    i_valid;
  logic [8*BEAT_BYTES-1:0] i_data;
  logic                    i_ack;
  logic                    o_ready;
  logic                    o_busy;
  logic                    o_done;
  logic [192*8-1:0]        o_ibytes;

  modport master (
    output i_start, i_eta, i_valid, i_data, i_ack,
    input  o_ready, o_busy, o_done, o_ibytes
  );

  modport slave (
    input  i_start, i_eta, i_valid, i_data, i_ack,
    output o_ready, o_busy, o_done, o_ibytes
  );
endinterface

// File: rtl/cbd_byte_loader.sv
// Gathers PRF squeeze beats into the 192-byte cbd input bus, right-aligned for eta=2,
// and holds the assembled bus until the consumer acknowledges it.
module cbd_byte_loader #(
  parameter int BEAT_BYTES = 8
) (
  input logic              i_clk,
  input logic              i_rst,
  cbd_byte_loader_if.slave bus
);
  localparam int NBEAT3 = 192 / BEAT_BYTES;
  localparam int NBEAT2 = 128 / BEAT_BYTES;
  localparam int CNT_W  = $clog2(NBEAT3 + 1);
  localparam int BEAT_W = 8 * BEAT_BYTES;

  localparam logic [CNT_W-1:0] LAST3 = CNT_W'(NBEAT3 - 1);
  localparam logic [CNT_W-1:0] LAST2 = CNT_W'(NBEAT2 - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]                     state_q;
  logic [CNT_W-1:0]               cnt_q;
  logic [1:0]                     eta_q;
  logic [NBEAT3-1:0][BEAT_W-1:0]  buffer_q;

  logic                           eta2;
  logic [CNT_W-1:0]               last;
  logic [CNT_W-1:0]               slot;
  logic [BEAT_BYTES-1:0][7:0]     beat_in;
  logic [BEAT_BYTES-1:0][7:0]     beat_rev;

  assign eta2 = (eta_q == 2'd2);
  assign last = eta2 ? LAST2 : LAST3;

  // Beat b lands in the slot (last - b): the first stream byte sits at the top of the
  // bus for eta=3, and at bit 1023 for eta=2, leaving the upper 64 bytes zero.
  assign slot    = last - cnt_q;
  assign beat_in = bus.i_data;

  // Stream byte 0 is the low byte of the beat but must occupy the highest byte of its slot.
  always_comb begin
    // NOTE: default assignment first so no path through the block can infer a latch.
    beat_rev = '0;
    for (int j = 0; j < BEAT_BYTES; j++) begin
      beat_rev[BEAT_BYTES-1-j] = beat_in[j];
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      eta_q    <= 2'd3;
      // NOTE: the buffer is reset too, because it drives o_ibytes straight to cbd.
      buffer_q <= '0;
    end else if (bus.i_start) begin
      // Start wins over a same-cycle beat and over i_ack, in every state.
      state_q  <= ST_LOAD;
      cnt_q    <= '0;
      eta_q    <= bus.i_eta;
      buffer_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_LOAD: begin
          if (bus.i_valid) begin
            buffer_q[slot] <= beat_rev;
            cnt_q          <= cnt_q + 1'b1;
            if (cnt_q == last) begin
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (bus.i_ack) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_ready  = (state_q == ST_LOAD);
  assign bus.o_busy   = (state_q == ST_LOAD);
  assign bus.o_done   = (state_q == ST_DONE);
  assign bus.o_ibytes = buffer_q;

endmodule

// File: tb/tb_cbd_byte_loader.sv
// Bench for cbd_byte_loader: table-driven loads, randomized valid/data, and hand-written
// reset / restart / acknowledge corner cases against a byte-level reference model.
module tb_cbd_byte_loader;
  localparam int BB  = 8;
  localparam int NB3 = 192 / BB;
  localparam int NB2 = 128 / BB;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cbd_byte_loader_if #(.BEAT_BYTES(BB)) bus ();

  cbd_byte_loader #(.BEAT_BYTES(BB)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  // Reference stream: stream_b[k] is stream byte k of the current load.
  logic [7:0] stream_b [192];

  typedef struct {
    logic [1:0] eta;
    int         period;     // valid every period cycles; 0 = random valid
    int         mode;       // 0: byte k = k, 1: 8'hA5 ^ k, 2: random
    int         pre_beats;  // >0: abort an eta=3 load after this many beats, restart with a beat
    int         hold;       // cycles to sit in DONE with data driven before i_ack
    int         exp_cyc;    // edges from start edge to o_done, start edge counted; -1 = derive
  } vec_t;

  vec_t vecs [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic check_bus(input string name, input logic [1535:0] exp);
    logic [1535:0] act;
    int            bad;
    act = bus.o_ibytes;
    bad = -1;
    checks++;
    if (act !== exp) begin
      errors++;
      for (int k = 191; k >= 0; k--) begin
        if (act[1535-8*k -: 8] !== exp[1535-8*k -: 8]) bad = k;
      end
      $display("FAIL %s: bus byte %0d (bits %0d-) got %h want %h", name, bad, 1535 - 8*bad,
               act[1535-8*bad -: 8], exp[1535-8*bad -: 8]);
    end
  endtask

  function automatic logic [1535:0] expected_bus(input logic [1:0] eta);
    logic [1535:0] e;
    int            n;
    int            top;
    e   = '0;
    n   = (eta == 2'd2) ? 128 : 192;
    top = (eta == 2'd2) ? 1023 : 1535;
    for (int k = 0; k < n; k++) e[top-8*k -: 8] = stream_b[k];
    return e;
  endfunction

  task automatic fill_stream(input int mode);
    for (int k = 0; k < 192; k++) begin
      case (mode)
        0:       stream_b[k] = 8'(k);
        1:       stream_b[k] = 8'hA5 ^ 8'(k);
        default: stream_b[k] = 8'($urandom);
      endcase
    end
  endtask

  task automatic drive_beat(input int b);
    for (int j = 0; j < BB; j++) bus.i_data[8*j +: 8] = stream_b[b*BB + j];
  endtask

  task automatic feed_beats(input int count);
    for (int b = 0; b < count; b++) begin
      bus.i_valid = 1'b1;
      drive_beat(b);
      step();
    end
    bus.i_valid = 1'b0;
  endtask

  task automatic run_load(input vec_t v, input string name);
    int            n;
    int            sent;
    int            cyc;
    int            ph;
    int            last_edge;
    int            exp_c;
    logic          v_now;
    logic [1535:0] exp;
    n         = (v.eta == 2'd2) ? NB2 : NB3;
    sent      = 0;
    ph        = 0;
    last_edge = -1;
    fill_stream(v.mode);
    if (v.pre_beats > 0) begin
      bus.i_start = 1'b1;
      bus.i_eta   = 2'd3;
      bus.i_valid = 1'b0;
      step();
      bus.i_start = 1'b0;
      for (int i = 0; i < v.pre_beats; i++) begin
        bus.i_valid = 1'b1;
        bus.i_data  = {$urandom, $urandom};
        step();
      end
      // This beat coincides with the restart and must be dropped.
      bus.i_valid = 1'b1;
      bus.i_data  = {$urandom, $urandom};
    end else begin
      bus.i_valid = 1'b0;
    end
    bus.i_start = 1'b1;
    bus.i_eta   = v.eta;
    step();
    bus.i_start = 1'b0;
    cyc = 1;
    if (v.pre_beats > 0) check_bus({name, " cleared"}, '0);
    check({name, " busy"}, bus.o_busy, 1);
    check({name, " ready"}, bus.o_ready, 1);
    while (!bus.o_done && cyc < 400) begin
      if (sent >= n)          v_now = 1'b0;
      else if (v.period == 0) v_now = ($urandom_range(0, 1) == 1);
      else                    v_now = ((ph % v.period) == 0);
      bus.i_valid = v_now;
      if (v_now) drive_beat(sent);
      else       bus.i_data = {$urandom, $urandom};
      step();
      cyc++;
      ph++;
      if (v_now) begin
        sent++;
        if (sent == n) last_edge = cyc;
      end
    end
    check({name, " done"}, bus.o_done, 1);
    exp_c = (v.exp_cyc >= 0) ? v.exp_cyc : last_edge;
    check({name, " cycles"}, cyc, exp_c);
    check({name, " ready in done"}, bus.o_ready, 0);
    check({name, " busy in done"}, bus.o_busy, 0);
    exp = expected_bus(v.eta);
    check_bus({name, " bus"}, exp);
    for (int i = 0; i < v.hold; i++) begin
      bus.i_valid = 1'b1;
      bus.i_data  = {$urandom, $urandom};
      step();
      check_bus({name, " held"}, exp);
      check({name, " ready held"}, bus.o_ready, 0);
      check({name, " done held"}, bus.o_done, 1);
    end
    bus.i_valid = 1'b0;
    bus.i_ack   = 1'b1;
    step();
    bus.i_ack = 1'b0;
    check({name, " done after ack"}, bus.o_done, 0);
    check({name, " busy after ack"}, bus.o_busy, 0);
    check_bus({name, " bus after ack"}, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic [1535:0] exp;

    vecs[0] = '{eta: 2'd3, period: 1, mode: 0, pre_beats: 0, hold: 10, exp_cyc: 25};
    vecs[1] = '{eta: 2'd2, period: 1, mode: 1, pre_beats: 0, hold: 0,  exp_cyc: 17};
    vecs[2] = '{eta: 2'd3, period: 3, mode: 0, pre_beats: 0, hold: 3,  exp_cyc: 71};
    vecs[3] = '{eta: 2'd2, period: 1, mode: 2, pre_beats: 5, hold: 2,  exp_cyc: 17};
    vecs[4] = '{eta: 2'd0, period: 1, mode: 2, pre_beats: 0, hold: 1,  exp_cyc: 25};
    vecs[5] = '{eta: 2'd1, period: 2, mode: 2, pre_beats: 0, hold: 0,  exp_cyc: 48};
    vecs[6] = '{eta: 2'd2, period: 3, mode: 2, pre_beats: 0, hold: 1,  exp_cyc: 47};
    vecs[7] = '{eta: 2'd3, period: 0, mode: 2, pre_beats: 3, hold: 1,  exp_cyc: -1};

    rst         = 1'b1;
    bus.i_start = 1'b0;
    bus.i_eta   = 2'd0;
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    bus.i_ack   = 1'b0;
    step();
    step();
    check("reset ready", bus.o_ready, 0);
    check("reset busy", bus.o_busy, 0);
    check("reset done", bus.o_done, 0);
    check_bus("reset bus", '0);
    rst = 1'b0;

    // IDLE ignores beats and acknowledges.
    bus.i_valid = 1'b1;
    bus.i_data  = {$urandom, $urandom};
    bus.i_ack   = 1'b1;
    step();
    step();
    bus.i_valid = 1'b0;
    bus.i_ack   = 1'b0;
    check("idle busy", bus.o_busy, 0);
    check("idle done", bus.o_done, 0);
    check_bus("idle bus", '0);

    for (int i = 0; i < 8; i++) run_load(vecs[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 6; i++) begin
      v.eta       = 2'($urandom_range(0, 3));
      v.period    = 0;
      v.mode      = 2;
      v.pre_beats = $urandom_range(0, 1) * $urandom_range(1, 10);
      v.hold      = $urandom_range(0, 3);
      v.exp_cyc   = -1;
      run_load(v, $sformatf("rnd%0d", i));
    end

    // Reset in the middle of a load.
    fill_stream(2);
    bus.i_start = 1'b1;
    bus.i_eta   = 2'd3;
    step();
    bus.i_start = 1'b0;
    feed_beats(7);
    bus.i_valid = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst load ready", bus.o_ready, 0);
    check("rst load busy", bus.o_busy, 0);
    check("rst load done", bus.o_done, 0);
    check_bus("rst load bus", '0);
    for (int i = 0; i < 3; i++) begin
      bus.i_data = {$urandom, $urandom};
      step();
    end
    bus.i_valid = 1'b0;
    check("rst idle busy", bus.o_busy, 0);
    check_bus("rst idle bus", '0);

    // Reset while in DONE.
    fill_stream(1);
    bus.i_start = 1'b1;
    bus.i_eta   = 2'd2;
    step();
    bus.i_start = 1'b0;
    feed_beats(NB2);
    check("pre-rst done", bus.o_done, 1);
    check_bus("pre-rst bus", expected_bus(2'd2));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst done done", bus.o_done, 0);
    check("rst done ready", bus.o_ready, 0);
    check_bus("rst done bus", '0);

    // i_start with i_ack in DONE: restart wins, then finish an eta=2 load.
    fill_stream(2);
    bus.i_start = 1'b1;
    bus.i_eta   = 2'd3;
    step();
    bus.i_start = 1'b0;
    feed_beats(NB3);
    check("prio first done", bus.o_done, 1);
    fill_stream(1);
    bus.i_start = 1'b1;
    bus.i_ack   = 1'b1;
    bus.i_eta   = 2'd2;
    step();
    bus.i_start = 1'b0;
    bus.i_ack   = 1'b0;
    check("prio busy", bus.o_busy, 1);
    check("prio done", bus.o_done, 0);
    check_bus("prio cleared", '0);
    feed_beats(NB2);
    check("prio second done", bus.o_done, 1);
    exp = expected_bus(2'd2);
    check_bus("prio second bus", exp);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
